// File: rtl/axil_mult_slave.sv
// AXI4-Lite slave wrapping a sequential 32x32 unsigned shift-add multiplier.
// Define MULT_IRQ_EN to add the irq output and the CTRL.IRQ_ENA bit.
module axil_mult_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
`ifdef MULT_IRQ_EN
    ,
    output logic                            irq
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_CALC
    } state_t;

    localparam logic [2:0] ADDR_OPA    = 3'd0;
    localparam logic [2:0] ADDR_OPB    = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_RES_LO = 3'd3;
    localparam logic [2:0] ADDR_RES_HI = 3'd4;

    // AXI channel state
    logic        aw_ready_q;
    logic        bvalid_q;
    logic        ar_ready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // Programmer-visible registers
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [63:0] result_q;
    logic        busy_q;
    logic        done_q;
    logic        irq_ena_q;

    // Multiplier datapath
    state_t      state_q;
    state_t      state_d;
    logic [63:0] a_sh_q;
    logic [31:0] b_sh_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_sum;

    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;
    logic        wr_en;
    logic        rd_en;
    logic        start_req;
    logic        start_go;
    logic        calc_last;
    logic [31:0] rd_mux;

    logic        unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];

    // READY is a one-cycle pulse; the handshake completes on the edge that ends it.
    assign wr_en = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en = ar_ready_q & S_AXI_ARVALID;

    assign start_req = wr_en && (wr_idx == ADDR_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, whatever order the statements run in.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            aw_ready_q <= ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            ar_ready_q <= ~ar_ready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            ADDR_OPA:    rd_mux = opa_q;
            ADDR_OPB:    rd_mux = opb_q;
            ADDR_CTRL:   rd_mux = {28'd0, irq_ena_q, done_q, busy_q, 1'b0};
            ADDR_RES_LO: rd_mux = result_q[31:0];
            ADDR_RES_HI: rd_mux = result_q[63:32];
            default:     rd_mux = '0;
        endcase
    end

    // Operand registers stay writable while busy; the shadow copies protect the run.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            opa_q     <= '0;
            opb_q     <= '0;
            irq_ena_q <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    if (wr_idx == ADDR_OPA) opa_q[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
                    if (wr_idx == ADDR_OPB) opb_q[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
                end
            end
`ifdef MULT_IRQ_EN
            if (wr_idx == ADDR_CTRL && S_AXI_WSTRB[0]) begin
                irq_ena_q <= S_AXI_WDATA[3];
            end
`endif
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        calc_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    start_go = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == 5'd31) begin
                    calc_last = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_sum = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

    // One multiplier bit per cycle; the final partial sum goes straight to RESULT.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_go) begin
            a_sh_q <= {32'd0, opa_q};
            b_sh_q <= opb_q;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (state_q == ST_CALC) begin
            acc_q  <= acc_sum;
            a_sh_q <= a_sh_q << 1;
            b_sh_q <= b_sh_q >> 1;
            cnt_q  <= cnt_q + 5'd1;
            if (calc_last) begin
                result_q <= acc_sum;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
            end
        end
    end

`ifdef MULT_IRQ_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= done_q & irq_ena_q;
        end
    end
`endif

endmodule

// File: tb/tb_axil_mult_slave.sv
// Self-checking bench for axil_mult_slave: directed bus sequences plus random
// operands checked against a plain 64-bit multiply reference.
module tb_axil_mult_slave;

    localparam logic [4:0] A_OPA    = 5'h00;
    localparam logic [4:0] A_OPB    = 5'h04;
    localparam logic [4:0] A_CTRL   = 5'h08;
    localparam logic [4:0] A_RES_LO = 5'h0C;
    localparam logic [4:0] A_RES_HI = 5'h10;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESETN;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
`ifdef MULT_IRQ_EN
    logic        irq;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic irq_ena_m = 1'b0;

    always #5 tb_ACLK = ~tb_ACLK;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    axil_mult_slave dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (tb_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
`ifdef MULT_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires B.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int stall, output int acc_edge);
        bit got;
        int n;
        acc_edge = -1;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_AWREADY) got = 1;
        end
        if (!got) begin
            check("awready_timeout", S_AXI_AWREADY, 1'b1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            return;
        end
        check("wready_with_awready", S_AXI_WREADY, 1'b1);
        @(posedge tb_ACLK); #1;
        acc_edge = cyc;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("awready_one_cycle", S_AXI_AWREADY, 1'b0);
        got = 0; n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            n++;
            if (S_AXI_BVALID) got = 1;
        end
        check("bvalid_latency", n, 1);
        if (!got) return;
        check("bresp", S_AXI_BRESP, 2'b00);
        for (int i = 0; i < stall; i++) begin
            @(negedge tb_ACLK);
            check("bvalid_hold", S_AXI_BVALID, 1'b1);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_BREADY = 1'b0;
        check("bvalid_drop", S_AXI_BVALID, 1'b0);
    endtask

    // h is the index of the edge on which the address handshake completed.
    task automatic axi_read(input logic [4:0] addr, input int stall, input logic [31:0] stall_exp,
                            output logic [31:0] data, output int h);
        bit got;
        int n;
        data = '0; h = -1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            if (S_AXI_ARREADY) got = 1;
        end
        if (!got) begin
            check("arready_timeout", S_AXI_ARREADY, 1'b1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(posedge tb_ACLK); #1;
        h = cyc;
        S_AXI_ARVALID = 1'b0;
        got = 0; n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            n++;
            if (S_AXI_RVALID) got = 1;
        end
        check("rvalid_latency", n, 1);
        if (!got) return;
        data = S_AXI_RDATA;
        check("rresp", S_AXI_RRESP, 2'b00);
        for (int i = 0; i < stall; i++) begin
            @(negedge tb_ACLK);
            check("rvalid_hold", S_AXI_RVALID, 1'b1);
            check("rdata_hold", S_AXI_RDATA, stall_exp);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge tb_ACLK); #1;
        end
    endtask

    // Status seen at handshake edge h reflects edges before h: BUSY after s, DONE after s+32.
    function automatic logic [31:0] status_at(input int s, input int h);
        logic done_m, busy_m;
        done_m = (h > s + 32);
        busy_m = (h > s) && !done_m;
        return {28'd0, irq_ena_m, done_m, busy_m, 1'b0};
    endfunction

    task automatic wait_done(input int s);
        logic [31:0] d;
        int h;
        d = '0;
        for (int n = 0; n < 40; n++) begin
            axi_read(A_CTRL, 0, '0, d, h);
            check("poll_status", d, status_at(s, h));
            if (d[2]) break;
        end
        check("done_seen", d[2], 1'b1);
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] p;
        logic [31:0] d;
        int s, h, dmy;
        p = 64'(a) * 64'(b);
        axi_write(A_OPA, a, 4'hF, 0, dmy);
        axi_write(A_OPB, b, 4'hF, 0, dmy);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, s);
        wait_done(s);
        axi_read(A_RES_LO, 0, '0, d, h);
        check({tag, "_lo"}, d, p[31:0]);
        axi_read(A_RES_HI, 0, '0, d, h);
        check({tag, "_hi"}, d, p[63:32]);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] b;
        int s, h, dmy;

        // Reset with valids asserted: nothing may handshake
        tb_ARESETN = 1'b0;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        repeat (3) begin
            @(negedge tb_ACLK);
            check("rst_awready", S_AXI_AWREADY, 1'b0);
            check("rst_wready", S_AXI_WREADY, 1'b0);
            check("rst_arready", S_AXI_ARREADY, 1'b0);
            check("rst_bvalid", S_AXI_BVALID, 1'b0);
            check("rst_rvalid", S_AXI_RVALID, 1'b0);
            check("rst_rdata", S_AXI_RDATA, 32'h0);
        end
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK); #1;

        axi_read(A_OPA, 0, '0, d, h);    check("post_rst_opa", d, 32'h0);
        axi_read(A_CTRL, 0, '0, d, h);   check("post_rst_ctrl", d, 32'h0);
        axi_read(A_RES_LO, 0, '0, d, h); check("post_rst_res_lo", d, 32'h0);

        // Byte strobes
        axi_write(A_OPA, 32'h0101FFFF, 4'hF, 0, dmy);
        axi_write(A_OPA, 32'hDEADBE11, 4'b0001, 0, dmy);
        axi_read(A_OPA, 0, '0, d, h);    check("wstrb_opa", d, 32'h0101FF11);
        axi_write(A_OPB, 32'h12345678, 4'b1010, 0, dmy);
        axi_read(A_OPB, 0, '0, d, h);    check("wstrb_opb", d, 32'h12005600);

        // IRQ_ENA exists only in the irq build
`ifdef MULT_IRQ_EN
        irq_ena_m = 1'b1;
`endif
        axi_write(A_CTRL, 32'h0000_0008, 4'h1, 0, dmy);
        axi_read(A_CTRL, 0, '0, d, h);   check("ctrl_irq_ena", d, {28'd0, irq_ena_m, 3'b000});

        // 0xFFFF x 0x10001: BUSY on the last cycle before DONE, then DONE
        axi_write(A_OPA, 32'h0000FFFF, 4'hF, 0, dmy);
        axi_write(A_OPB, 32'h00010001, 4'hF, 0, dmy);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, s);
        wait_cyc(s + 30);
        axi_read(A_CTRL, 0, '0, d, h);
        check("busy_edge_h", h, s + 32);
        check("busy_before_done", d, {28'd0, irq_ena_m, 3'b010});
        wait_done(s);
        axi_read(A_RES_LO, 0, '0, d, h); check("p1_lo", d, 32'hFFFFFFFF);
        axi_read(A_RES_HI, 0, '0, d, h); check("p1_hi", d, 32'h00000000);
`ifdef MULT_IRQ_EN
        check("irq_after_done", irq, 1'b1);
`endif

        // All-ones operands; RESULT keeps the old product while running
        axi_write(A_OPA, 32'hFFFFFFFF, 4'hF, 0, dmy);
        axi_write(A_OPB, 32'hFFFFFFFF, 4'hF, 0, dmy);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, s);
`ifdef MULT_IRQ_EN
        check("irq_clr_on_start", irq, 1'b0);
`endif
        axi_read(A_RES_LO, 0, '0, d, h); check("result_held", d, 32'hFFFFFFFF);
        wait_cyc(s + 31);
        axi_read(A_CTRL, 0, '0, d, h);
        check("done_edge_h", h, s + 33);
        check("done_at_32", d, {28'd0, irq_ena_m, 3'b100});
        axi_read(A_RES_LO, 0, '0, d, h); check("p2_lo", d, 32'h00000001);
        axi_read(A_RES_HI, 0, '0, d, h); check("p2_hi", d, 32'hFFFFFFFE);
`ifdef MULT_IRQ_EN
        check("irq_after_done2", irq, 1'b1);
        irq_ena_m = 1'b0;
        axi_write(A_CTRL, 32'h0, 4'h1, 0, dmy);
        check("irq_clr_on_ena0", irq, 1'b0);
        irq_ena_m = 1'b1;
        axi_write(A_CTRL, 32'h8, 4'h1, 0, dmy);
`endif

        // START and OPA write during a run do not disturb it
        axi_write(A_OPA, 32'd7, 4'hF, 0, dmy);
        axi_write(A_OPB, 32'd9, 4'hF, 0, dmy);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, s);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, dmy);
        axi_write(A_OPA, 32'd5, 4'hF, 0, dmy);
        axi_read(5'h14, 0, '0, d, h);    check("unmapped_14", d, 32'h0);
        axi_write(5'h18, 32'hA5A5A5A5, 4'hF, 0, dmy);
        axi_read(5'h18, 0, '0, d, h);    check("unmapped_18", d, 32'h0);
        wait_done(s);
        axi_read(A_RES_LO, 0, '0, d, h); check("midrun_lo", d, 32'd63);
        axi_read(A_RES_HI, 0, '0, d, h); check("midrun_hi", d, 32'd0);
        axi_read(A_OPA, 0, '0, d, h);    check("midrun_opa", d, 32'd5);
        axi_read(A_OPB, 0, '0, d, h);    check("opb_after_unmapped", d, 32'd9);

        // Back-pressure on B and R
        axi_write(A_OPB, 32'h0BADF00D, 4'hF, 5, dmy);
        axi_read(A_OPB, 5, 32'h0BADF00D, d, h);
        check("stall_read", d, 32'h0BADF00D);

        // Same-cycle read and write of OPB returns the pre-write value
        fork
            axi_write(A_OPB, 32'hCAFE0001, 4'hF, 0, dmy);
            axi_read(A_OPB, 0, '0, d, h);
        join
        check("rd_wr_same_cycle", d, 32'h0BADF00D);
        axi_read(A_OPB, 0, '0, d, h);    check("rd_after_wr", d, 32'hCAFE0001);

        // Random and corner operands against plain multiplication
        run_mult(32'h0, $urandom, "zero_a");
        run_mult($urandom, 32'h1, "one_b");
        run_mult(32'h80000000, 32'h80000000, "msb");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            run_mult(a, b, "rand");
        end

        // Reset in the middle of a computation
        axi_write(A_OPA, 32'h12345678, 4'hF, 0, dmy);
        axi_write(A_OPB, 32'h9ABCDEF0, 4'hF, 0, dmy);
        axi_write(A_CTRL, {28'd0, irq_ena_m, 3'b001}, 4'h1, 0, s);
        wait_cyc(s + 10);
        @(negedge tb_ACLK);
        tb_ARESETN = 1'b0;
        #1;
        check("midrst_bvalid", S_AXI_BVALID, 1'b0);
        check("midrst_rvalid", S_AXI_RVALID, 1'b0);
`ifdef MULT_IRQ_EN
        check("midrst_irq", irq, 1'b0);
`endif
        irq_ena_m = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK); #1;
        axi_read(A_CTRL, 0, '0, d, h);   check("midrst_ctrl", d, 32'h0);
        axi_read(A_RES_LO, 0, '0, d, h); check("midrst_res_lo", d, 32'h0);
        axi_read(A_RES_HI, 0, '0, d, h); check("midrst_res_hi", d, 32'h0);
        axi_read(A_OPA, 0, '0, d, h);    check("midrst_opa", d, 32'h0);

        // Engine still works after the reset
        run_mult(32'h0000ABCD, 32'h00001234, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed cyc=%0d expected completion", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/axil_mult_slave.md
Name: axil_mult_slave

Overview:
- AXI4-Lite slave peripheral exposing a sequential 32x32 unsigned shift-add multiplier through memory-mapped registers.
- Responder end of the AXI4-Lite link driven by the block-design master BFM; instantiated inside the multiplier IP wrapper.
- Software writes operands, pulses START, polls DONE, then reads the 64-bit product.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses bits [4:2].

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- irq  out  1  present only with MULT_IRQ_EN.

Behaviour:
- Reset: asynchronous and active-low. All READY/VALID outputs 0, RDATA 0, OPA/OPB/RESULT 0, BUSY 0, DONE 0, FSM IDLE.
- Register map:
  - 0x00 OPA (RW, WSTRB honoured).
  - 0x04 OPB (RW, WSTRB honoured).
  - 0x08 CTRL:
    - bit0 START, write-1 pulse, reads 0.
    - bit1 BUSY, RO.
    - bit2 DONE, RO, sticky.
    - bit3 IRQ_ENA, RW; present only with MULT_IRQ_EN, else reads 0.
  - 0x0C RESULT_LO (RO).
  - 0x10 RESULT_HI (RO).
  - 0x14–0x1C unmapped: reads return 0, writes dropped. BRESP/RRESP stay OKAY.
- Write channel:
  - AW and W accepted together only when AWVALID and WVALID are both high and BVALID is low.
  - AWREADY and WREADY pulse high for exactly 1 cycle; register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY is sampled high.
  - No new write is accepted while BVALID is high.
- Read channel:
  - ARREADY pulses 1 cycle when ARVALID is high and RVALID is low.
  - RDATA is registered; RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
- Simultaneous read and write: both proceed independently. A read in the same cycle as a write returns the pre-write value.
- FSM IDLE:
  - Write to CTRL with WSTRB[0]=1 and WDATA[0]=1 latches OPA/OPB into shadow registers (a_sh 64b, b_sh 32b).
  - Same edge clears acc and cnt, clears DONE, sets BUSY, and moves to CALC.
- FSM CALC, per cycle:
  - if b_sh[0], acc <= acc + a_sh.
  - a_sh <<= 1; b_sh >>= 1; cnt++.
  - When cnt==31 this cycle: RESULT <= final acc, BUSY <= 0, DONE <= 1, go to IDLE.
- Latency: DONE reads 1 exactly 32 cycles after the edge that accepted START. Polling reads return BUSY=1 before that.
- START while BUSY is ignored; the running computation is unaffected.
- OPA/OPB writes while BUSY update the registers but not the shadow operands.
- RESULT holds its old value until the new computation completes.
- Reset mid-CALC: immediate return to IDLE with all state cleared; any in-flight AXI response is dropped.

Optional Feature:
- Macro MULT_IRQ_EN.
- Defined:
  - Port irq and CTRL bit3 IRQ_ENA exist.
  - irq = DONE & IRQ_ENA, registered, reset 0.
  - irq clears when DONE clears (next START) or when IRQ_ENA is written 0.
- Undefined: no irq port; CTRL bit3 reads 0 and writes are ignored; all other behaviour identical.

Test Plan:
- Post-reset read of 0x00, 0x08, 0x0C -> 0x00000000, RRESP 0; AWREADY/WREADY/ARREADY low during reset.
- Write OPA=0x0101FFFF, then write 0xDEADBE11 to 0x00 with WSTRB=4'b0001 -> read 0x00 returns 0x0101FF11.
- OPA=0x0000FFFF, OPB=0x00010001, START:
  - 0x08 reads 0x2 while busy.
  - DONE at start+32 cycles.
  - RESULT_LO=0xFFFFFFFF, RESULT_HI=0x00000000.
- OPA=OPB=0xFFFFFFFF, START -> RESULT_LO=0x00000001, RESULT_HI=0xFFFFFFFE.
- Mid-run second START plus OPA write of 0x5 -> first product unchanged, DONE still at cycle 32; read of unmapped 0x14 -> 0x0 OKAY.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RDATA stable; assert ARESETN low mid-CALC -> BUSY=0, DONE=0, RESULT=0. With MULT_IRQ_EN and IRQ_ENA=1 -> irq high after DONE, low after next START.
